// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the sequential ALU
//
// Purpose: ALU control encoding and FSM state type shared by the decoder,
//          the sequential ALU top and anything that wants to name them.
// Ports:   none (package).
package alu_pkg;

  typedef enum logic [3:0] {
    ADD     = 4'b0000,
    SUB     = 4'b0001,
    AND     = 4'b0010,
    OR      = 4'b0011,
    SLT     = 4'b0101,
    PASS    = 4'b0111,
    SRL     = 4'b1000,
    SRA     = 4'b1001,
    SLL     = 4'b1010,
    ILLEGAL = 4'b1111
  } alu_control_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational RISC-V style ALU control decode
//
// Purpose: map alu_op plus funct fields onto an alu_control_t operation.
// Ports:   alu_op      - 00 add, 01 sub, 10 decode funct fields, 11 pass
//          funct3      - RISC-V funct3
//          op_5        - opcode bit 5 (distinguishes R-type from I-type)
//          funct7_5    - funct7 bit 5 (sub / arithmetic shift select)
//          alu_control - decoded operation, ILLEGAL when undecodable
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0]   alu_op,
  input  logic [2:0]   funct3,
  input  logic         op_5,
  input  logic         funct7_5,
  output alu_control_t alu_control
);

  always_comb begin
    alu_control = ILLEGAL;
    case (alu_op)
      2'b00: alu_control = ADD;
      2'b01: alu_control = SUB;
      2'b11: alu_control = PASS;
      default: begin
        case (funct3)
          // Only R-type (op_5=1) may select SUB; ADDI with funct7_5 set stays ADD.
          3'b000:  alu_control = (op_5 && funct7_5) ? SUB : ADD;
          3'b010:  alu_control = SLT;
          3'b110:  alu_control = OR;
          3'b111:  alu_control = AND;
          3'b001:  alu_control = SLL;
          3'b101:  alu_control = funct7_5 ? SRA : SRL;
          default: alu_control = ILLEGAL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with iterative shifter and valid/ready handshake
//
// Purpose: single-cycle add/sub/logic/slt/pass; shifts iterate SHIFT_STEP
//          bits per cycle. One operation in flight; result held until taken.
// Ports:   clk, rst            - clock, async active-high reset
//          in_valid / in_ready - operation handshake (ready only in IDLE)
//          alu_op, funct3, op_5, funct7_5 - operation select
//          a, b                - operands (b is passed through for PASS)
//          out_valid / out_ready - result handshake
//          result, zero, illegal - registered result, result==0, undecodable op
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             op_5,
  input  logic             funct7_5,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  alu_control_t     ctrl_in;
  alu_control_t     ctrl_q;
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result_q;
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    step;
  logic             illegal_q;
  logic             is_shift_in;

  alu_ctrl_decode u_decode (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_5        (op_5),
    .funct7_5    (funct7_5),
    .alu_control (ctrl_in)
  );

  // Single-cycle operations, evaluated on the operands being offered.
  always_comb begin
    alu_res     = '0;
    is_shift_in = 1'b0;
    case (ctrl_in)
      ADD:  alu_res = a + b;
      SUB:  alu_res = a - b;
      AND:  alu_res = a & b;
      OR:   alu_res = a | b;
      SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      PASS: alu_res = b;
      SRL, SRA, SLL: is_shift_in = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // Shift by min(SHIFT_STEP, cnt). When SHIFT_STEP == WIDTH the cast below
  // truncates to 0, but cnt < WIDTH always holds so that branch is never taken.
  always_comb begin
    if (32'(cnt) < 32'(SHIFT_STEP)) step = cnt;
    else                            step = SW'(SHIFT_STEP);
    case (ctrl_q)
      SLL:     shifted = acc << step;
      SRA:     shifted = $unsigned($signed(acc) >>> step);
      default: shifted = acc >> step;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // A zero-length shift has nothing to iterate; finish like a 1-cycle op.
          if (is_shift_in && (b[SW-1:0] != '0)) state_next = SHIFT;
          else                                   state_next = DONE;
        end
      end
      SHIFT: begin
        // The final partial step completes on the same edge that moves to DONE.
        if (cnt == step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= ADD;
      acc       <= '0;
      cnt       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        ctrl_q    <= ctrl_in;
        illegal_q <= (ctrl_in == ILLEGAL);
        if (is_shift_in) begin
          acc      <= a;
          cnt      <= b[SW-1:0];
          result_q <= a;
        end else begin
          result_q <= alu_res;
        end
      end
    end else if (state == SHIFT) begin
      acc <= shifted;
      cnt <= cnt - step;
      if (cnt == step) result_q <= shifted;
    end
  end

  assign result  = result_q;
  assign zero    = (result_q == '0);
  assign illegal = illegal_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; power of two, 8..64.
REQ-002 Parameter SHIFT_STEP, default 1, maximum shift bits per cycle; power of two, 1..WIDTH.
REQ-003 The module SHALL use one clock and an asynchronous, active-high reset; ports are clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  async active-high reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 alu_op  input  2  00 add, 01 sub, 10 decode funct fields, 11 pass.
REQ-009 funct3  input  3  RISC-V funct3.
REQ-010 op_5  input  1  opcode bit 5.
REQ-011 funct7_5  input  1  funct7 bit 5.
REQ-012 a, b  input  WIDTH each  operands; b is passed through for alu_op 11.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 result  output  WIDTH  operation result.
REQ-016 zero  output  1  result == 0.
REQ-017 illegal  output  1  undecodable operation flag, valid with out_valid.

Function
REQ-018 The control decode SHALL be: alu_op 00 -> ADD, 01 -> SUB, 11 -> PASS. For alu_op 10, funct3 000 -> SUB when {op_5,funct7_5}=11, else ADD; 010 -> SLT (signed); 110 -> OR; 111 -> AND; 001 -> SLL; 101 -> SRA when funct7_5=1, else SRL.
REQ-019 Any other funct3 under alu_op 10 SHALL be illegal: result 0, illegal 1, normal latency.
REQ-020 FSM states SHALL be IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-021 An operation SHALL be accepted on a clk edge where in_valid && in_ready; operands and decode are captured at that edge.
REQ-022 A non-shift operation SHALL go IDLE -> DONE, with result registered and out_valid high 1 cycle after the accept edge.
REQ-023 A shift operation SHALL load acc=a and cnt=b[log2(WIDTH)-1:0]. If cnt=0, it goes directly to DONE with result=a.
REQ-024 In SHIFT, each cycle SHALL shift acc by min(SHIFT_STEP, cnt) and decrement cnt by the same amount; when cnt reaches 0 the block moves to DONE.
REQ-025 Shift latency SHALL be ceil(shamt/SHIFT_STEP)+1 cycles from accept to out_valid.
REQ-026 SRA SHALL fill with acc[WIDTH-1]; SLL and SRL SHALL fill with 0.
REQ-027 ADD/SUB SHALL wrap modulo 2^WIDTH, with no carry or overflow outputs.
REQ-028 SLT SHALL produce a zero-extended result of 1 when signed a < signed b.
REQ-029 In DONE, out_valid=1; result, zero and illegal SHALL stay stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-030 DONE and the next accept SHALL NOT occur in the same cycle, giving a peak throughput of one operation per 2 cycles.
REQ-031 in_valid outside IDLE SHALL be ignored, with no side effects.
REQ-032 zero SHALL be derived from the registered result.

Reset
REQ-033 While rst=1: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0, acc=0, cnt=0, regardless of operation in progress.
REQ-034 An operation in flight at reset SHALL be discarded; no out_valid for it after release.

Structure
REQ-035 Package alu_pkg SHALL hold the alu_control_t 4-bit enum and the state_t enum. alu_control_t encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0101, PASS 0111, SRL 1000, SRA 1001, SLL 1010, ILLEGAL 1111.
REQ-036 Combinational decode SHALL live in one sub-module alu_ctrl_decode (funct3, op_5, funct7_5, alu_op -> alu_control_t); the shifter and FSM stay in seq_alu.

Verification (WIDTH=32, SHIFT_STEP=1 unless stated)
REQ-037 ADD: alu_op=10, funct3=000, op_5=1, funct7_5=0, a=5, b=7 -> out_valid 1 cycle after accept, result=12, zero=0.
REQ-038 SUB/SLT: op_5=1, funct7_5=1, a=7, b=7 -> result=0, zero=1. funct3=010, a=0xFFFFFFFF, b=1 -> result=1.
REQ-039 SRA: funct3=101, funct7_5=1, a=0x80000000, b=4 -> out_valid 5 cycles after accept, result=0xF8000000. With SHIFT_STEP=4, out_valid 2 cycles after accept.
REQ-040 Backpressure: hold out_ready=0 for 6 cycles in DONE while driving in_valid=1 -> result stable, in_ready=0, no new accept; release -> IDLE next cycle.
REQ-041 Reset mid-op: SLL, a=1, b=31, assert rst 10 cycles after accept -> out_valid=0, result=0 immediately, in_ready=1 after release, no late out_valid.
REQ-042 Illegal: alu_op=10, funct3=011 -> out_valid 1 cycle after accept, illegal=1, result=0.
